// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one synchronous-read 32-bit ROM port between two requesters
//   (port 0 = instruction fetch, port 1 = data/load path). Round-robin
//   arbitration. The ROM response is held until the owning port takes it.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_reqN_valid/i_reqN_addr/o_reqN_ready   request channel, N = 0/1
//   o_respN_valid/o_respN_data/i_respN_ready response channel, N = 0/1
//   o_rom_addr / i_rom_data             ROM port (ROM registers the address)
//   o_busy                              a transaction is in flight
module rom_port_arbiter #(
  parameter int DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req0_valid,
  input  logic [$clog2(DEPTH)-1:0] i_req0_addr,
  output logic                     o_req0_ready,
  output logic                     o_resp0_valid,
  output logic [31:0]              o_resp0_data,
  input  logic                     i_resp0_ready,
  input  logic                     i_req1_valid,
  input  logic [$clog2(DEPTH)-1:0] i_req1_addr,
  output logic                     o_req1_ready,
  output logic                     o_resp1_valid,
  output logic [31:0]              o_resp1_data,
  input  logic                     i_resp1_ready,
  output logic [$clog2(DEPTH)-1:0] o_rom_addr,
  input  logic [31:0]              i_rom_data,
  output logic                     o_busy
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic                  owner, last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           resp_data_q;

  logic                  owner_ready, accept, grant, grant_sel;
  logic [ADDR_WIDTH-1:0] grant_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      addr_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= grant_sel;
        last_grant <= grant_sel;
        addr_q     <= grant_addr;
      end
      if (state == WAIT) resp_data_q <= i_rom_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_ready   = owner ? i_resp1_ready : i_resp0_ready;
    accept        = (state == IDLE) || ((state == RESP) && owner_ready);
    // Gated by reset so no request is acknowledged while held in reset.
    grant         = i_rst_n && accept && (i_req0_valid || i_req1_valid);
    // Tie goes to the port that did not win last; otherwise the lone requester.
    grant_sel     = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
    grant_addr    = grant_sel ? i_req1_addr : i_req0_addr;
    o_req0_ready  = grant && !grant_sel;
    o_req1_ready  = grant && grant_sel;
    // ROM registers this at the grant edge, so data lands during WAIT.
    o_rom_addr    = grant ? grant_addr : addr_q;
    o_resp0_valid = (state == RESP) && !owner;
    o_resp1_valid = (state == RESP) && owner;
    o_resp0_data  = resp_data_q;
    o_resp1_data  = resp_data_q;
    o_busy        = (state != IDLE);
    case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (owner_ready) state_nxt = grant ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//   Directed scenarios followed by constrained-random traffic, each cycle
//   compared against a transaction-level model: at most one read in flight,
//   visible two cycles after its grant, round-robin on ties.
module tb_rom_port_arbiter;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  logic          i_clk, i_rst_n;
  logic          i_req0_valid, i_req1_valid, i_resp0_ready, i_resp1_ready;
  logic [AW-1:0] i_req0_addr, i_req1_addr, o_rom_addr;
  logic          o_req0_ready, o_req1_ready, o_resp0_valid, o_resp1_valid, o_busy;
  logic [31:0]   o_resp0_data, o_resp1_data, i_rom_data;

  rom_port_arbiter #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr), .o_req0_ready(o_req0_ready),
    .o_resp0_valid(o_resp0_valid), .o_resp0_data(o_resp0_data), .i_resp0_ready(i_resp0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_addr(i_req1_addr), .o_req1_ready(o_req1_ready),
    .o_resp1_valid(o_resp1_valid), .o_resp1_data(o_resp1_data), .i_resp1_ready(i_resp1_ready),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous-read ROM attached to the arbiter
  logic [31:0] rom_mem [DEPTH];
  always @(posedge i_clk) i_rom_data <= rom_mem[o_rom_addr];

  int tests = 0, fails = 0;

  // Transaction-level model
  int          m_owner;     // -1: nothing in flight
  int          m_issue;     // cycle of the grant
  int          m_last;      // last granted port
  logic [AW-1:0] m_last_addr;
  logic [31:0] m_data;
  int          cyc = 0;
  int          obs_grant [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner     = -1;
    m_last      = 1;
    m_last_addr = '0;
  endtask

  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic v1,
                      input logic [AW-1:0] a1, input logic r0, input logic r1,
                      output int g);
    bit vis, hs;
    logic [AW-1:0] ga;
    i_req0_valid = v0; i_req0_addr = a0; i_req1_valid = v1; i_req1_addr = a1;
    i_resp0_ready = r0; i_resp1_ready = r1;
    #3;
    vis = (m_owner >= 0) && (cyc >= m_issue + 2);
    hs  = vis && ((m_owner == 0) ? r0 : r1);
    g   = -1;
    if ((m_owner < 0 || hs) && (v0 || v1))
      g = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
    ga = (g == 1) ? a1 : a0;
    chk("req0_ready",  o_req0_ready,  g == 0);
    chk("req1_ready",  o_req1_ready,  g == 1);
    chk("busy",        o_busy,        m_owner >= 0);
    chk("rom_addr",    o_rom_addr,    (g >= 0) ? ga : m_last_addr);
    chk("resp0_valid", o_resp0_valid, vis && m_owner == 0);
    chk("resp1_valid", o_resp1_valid, vis && m_owner == 1);
    if (vis) begin
      chk("resp0_data", o_resp0_data, m_data);
      chk("resp1_data", o_resp1_data, m_data);
    end
    if (o_req0_ready) obs_grant.push_back(0);
    if (o_req1_ready) obs_grant.push_back(1);
    if (hs) m_owner = -1;
    if (g >= 0) begin
      m_owner = g; m_issue = cyc; m_last = g; m_last_addr = ga; m_data = rom_mem[ga];
    end
    cyc++;
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 1, 1, g);
  endtask

  initial begin
    int g;
    logic rv0, rv1;
    logic [AW-1:0] ra0, ra1;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'hDEADBEEF;

    // Reset state, with a request already pending
    i_rst_n = 1'b0; i_req0_valid = 1'b1; i_req0_addr = 5; i_req1_valid = 1'b0;
    i_req1_addr = '0; i_resp0_ready = 1'b1; i_resp1_ready = 1'b1;
    #3;
    chk("rst_req0_ready", o_req0_ready, 0);
    chk("rst_req1_ready", o_req1_ready, 0);
    chk("rst_resp0_valid", o_resp0_valid, 0);
    chk("rst_resp1_valid", o_resp1_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rom_addr", o_rom_addr, 0);
    chk("rst_resp_data", o_resp0_data, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();

    // Single read of ROM[5] on port 0
    step(1, 5, 0, '0, 1, 1, g);
    idle(4);

    // Tie after reset then continuous contention: strict alternation
    do_reset();
    obs_grant.delete();
    for (int i = 0; i < 16; i++) step(1, 2, 1, 3, 1, 1, g);
    chk("fair_count", obs_grant.size(), 8);
    for (int k = 0; k < obs_grant.size(); k++) chk("fair_order", obs_grant[k], k % 2);

    // Backpressure on port 1 while port 0 waits
    do_reset();
    step(0, '0, 1, 7, 0, 0, g);
    for (int i = 0; i < 6; i++) step(1, 9, 0, '0, 1, 0, g);
    obs_grant.delete();
    step(1, 9, 0, '0, 1, 1, g);
    chk("bp_release_grant", obs_grant.size(), 1);
    idle(2);

    // Reset while in WAIT
    step(1, 11, 0, '0, 1, 1, g);
    i_req0_valid = 1'b1; i_req0_addr = 13;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rstw_req0_ready", o_req0_ready, 0);
    chk("rstw_busy", o_busy, 0);
    chk("rstw_resp0_valid", o_resp0_valid, 0);
    chk("rstw_resp1_valid", o_resp1_valid, 0);
    chk("rstw_rom_addr", o_rom_addr, 0);
    chk("rstw_resp_data", o_resp0_data, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
    idle(3);
    step(0, '0, 1, 20, 1, 1, g);
    idle(3);

    // Idle stability
    idle(10);

    // Random traffic with requester hold rules
    rv0 = 0; rv1 = 0; ra0 = '0; ra1 = '0;
    for (int i = 0; i < 400; i++) begin
      step(rv0, ra0, rv1, ra1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), g);
      if (!rv0 || g == 0) begin rv0 = $urandom_range(0, 1); ra0 = AW'($urandom); end
      if (!rv1 || g == 1) begin rv1 = $urandom_range(0, 1); ra1 = AW'($urandom); end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one synchronous-read 32-bit ROM port (registered address, data valid the cycle after the address is presented) between two requesters.
- Port 0 is instruction fetch; port 1 is the data/load path.
- Each port has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. The response is buffered until the owning port accepts it.

Parameters:
- DEPTH, 512, ROM depth in 32-bit words; must match the attached ROM.
- ADDR_WIDTH, $clog2(DEPTH), word-address width (localparam).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_valid  in  1  port 0 read request
- i_req0_addr  in  ADDR_WIDTH  port 0 word address
- o_req0_ready  out  1  port 0 request accepted this cycle
- o_resp0_valid  out  1  port 0 read data valid
- o_resp0_data  out  32  port 0 read data
- i_resp0_ready  in  1  port 0 consumes response
- i_req1_valid, i_req1_addr, o_req1_ready, o_resp1_valid, o_resp1_data, i_resp1_ready: same as port 0, for port 1
- o_rom_addr  out  ADDR_WIDTH  to ROM i_addr
- i_rom_data  in  32  from ROM o_data
- o_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, owner=0, last_grant=1 (port 0 wins the first tie).
  - addr_q=0, resp_data_q=0.
  - All o_*_valid=0, all o_req*_ready=0, o_busy=0.
- States:
  - IDLE: no transaction.
  - WAIT: address presented last cycle; ROM data arrives this cycle.
  - RESP: response held for owner.
- Accept condition (combinational): accept = (state==IDLE) or (state==RESP and i_respX_ready of owner).
- Grant when accept is true and at least one request is valid:
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - o_reqN_ready=1 only for the granted port, only in that cycle. Never assert both ready signals.
  - On grant: owner<=N, last_grant<=N, addr_q<=i_reqN_addr, next state WAIT.
- o_rom_addr is combinational: the granted request address in a grant cycle, else addr_q. The ROM therefore registers the granted address at the grant edge.
- WAIT: resp_data_q<=i_rom_data; state<=RESP. WAIT cannot be stalled; i_resp*_ready is ignored.
- RESP:
  - o_respX_valid=1 for owner only. o_respX_data=resp_data_q.
  - Both o_resp*_data outputs carry resp_data_q; only valid qualifies them.
  - Owner handshake with a new grant in the same cycle -> WAIT (back-to-back).
  - Owner handshake with no request -> IDLE.
  - No handshake: hold valid and data stable; do not assert any request ready.
- Latency: request accepted at edge T -> response valid from T+2. Peak throughput is one read per 2 cycles when the responder is always ready.
- Handshake rules:
  - Requesters must hold valid and addr until ready.
  - The arbiter ignores addr changes while ready=0.
  - A non-owner's i_resp_ready is ignored.
- Starvation: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- Reset mid-operation (WAIT or RESP): immediately return to reset values. The in-flight read is dropped, not replayed, and no response is issued after reset.
- Address width: addresses are word indices with no range check. Values beyond DEPTH-1 wrap per the ROM's own indexing.

Test Plan:
- Single read: ROM[5]=0xDEADBEEF; port 0 valid addr 5 at cycle 1 -> o_req0_ready=1 cycle 1; o_resp0_valid=1, data 0xDEADBEEF from cycle 3; o_resp1_valid stays 0.
- Tie after reset: both valid at cycle 1 (addr 2, addr 3) -> port 0 granted cycle 1. Port 1 granted on the cycle its RESP handshake occurs (back-to-back). Responses ROM[2] then ROM[3].
- Fairness: both ports request continuously with resp_ready=1 for 8 transactions -> grant order 0,1,0,1,0,1,0,1; one grant every 2 cycles.
- Backpressure: port 1 response with i_resp1_ready=0 for 5 cycles -> o_resp1_valid and data held stable; o_req0_ready stays 0 despite port 0 valid. Release -> port 0 granted in the same cycle.
- Reset in WAIT: assert i_rst_n=0 mid-cycle after a grant -> all outputs 0 immediately (async). After release, no stale response appears; a fresh request completes normally.
- Idle stability: no requests for 10 cycles -> o_busy=0, o_rom_addr holds the last granted address, no ready/valid pulses.
